// File: rtl/iclark.sv
// Inverse Clarke transform sequencer: drives shared FP multipliers/adders through
// MULT and ADD phases of OP_LAT+1 cycles each, then latches U_u/U_v/U_w.
module iclark #(
   parameter int unsigned OP_LAT = 12
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] V_alpha,
   input  logic [31:0] V_beta,
   input  logic [31:0] re_add1,
   input  logic [31:0] re_add2,
   input  logic [31:0] re_mult1,
   input  logic [31:0] re_mult2,
   output logic [31:0] add1a,
   output logic [31:0] add1b,
   output logic [31:0] add2a,
   output logic [31:0] add2b,
   output logic        isadd1,
   output logic        isadd2,
   output logic [31:0] mult1a,
   output logic [31:0] mult1b,
   output logic [31:0] mult2a,
   output logic [31:0] mult2b,
   output logic [31:0] U_u,
   output logic [31:0] U_v,
   output logic [31:0] U_w,
   output logic        ack
);

   localparam int unsigned DW    = 32;
   localparam int unsigned CNT_W = 6;
   localparam logic [DW-1:0] HALF  = 32'h3F00_0000;
   localparam logic [DW-1:0] SQ3_2 = 32'h3F5D_B3D7;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      MULT  = 4'd1,
      ADD   = 4'd2,
      LATCH = 4'd3,
      DONE  = 4'd4
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DW-1:0]     alpha_r;
   logic              cnt_done;
   logic              start;
   logic              to_add;

   // State register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode; unused encodings fall back to IDLE
   always_comb begin
      next_state = IDLE;
      cnt_done   = (wait_cnt == CNT_W'(OP_LAT));
      start      = 1'b0;
      to_add     = 1'b0;
      case (state)
         IDLE: begin
            start      = en;
            next_state = en ? MULT : IDLE;
         end
         MULT: begin
            to_add     = cnt_done;
            next_state = cnt_done ? ADD : MULT;
         end
         ADD:     next_state = cnt_done ? LATCH : ADD;
         LATCH:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign ack = (state == DONE);

   // Phase wait counter: runs only while a busy state is held
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if ((next_state == state) && (state != IDLE))
         wait_cnt <= wait_cnt + CNT_W'(1);
      else
         wait_cnt <= '0;
   end

   // Operand and result registers, loaded only on their phase edges
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         alpha_r <= '0;
         mult1a  <= '0;
         mult1b  <= '0;
         mult2a  <= '0;
         mult2b  <= '0;
         add1a   <= '0;
         add1b   <= '0;
         add2a   <= '0;
         add2b   <= '0;
         isadd1  <= 1'b0;
         isadd2  <= 1'b0;
         U_u     <= '0;
         U_v     <= '0;
         U_w     <= '0;
      end else begin
         if (start) begin
            alpha_r <= V_alpha;
            mult1a  <= HALF;
            mult1b  <= V_alpha;
            mult2a  <= SQ3_2;
            mult2b  <= V_beta;
         end
         // U_v = sq3/2*beta - alpha/2 ; U_w = -(alpha/2) - sq3/2*beta
         if (to_add) begin
            add1a  <= re_mult2;
            add1b  <= re_mult1;
            isadd1 <= 1'b0;
            add2a  <= {~re_mult1[DW-1], re_mult1[DW-2:0]};
            add2b  <= re_mult2;
            isadd2 <= 1'b0;
         end
         if (state == LATCH) begin
            U_u <= alpha_r;
            U_v <= re_add1;
            U_w <= re_add2;
         end
      end
   end

endmodule

// File: tb/tb_iclark.sv
// Randomized bench for iclark: FP units modelled with OP_LAT-deep pipelines,
// expected values from a transaction-level timing/arithmetic model.
module tb_iclark;

   localparam int unsigned OP_LAT = 12;
   localparam int          T_UPD  = 2 * OP_LAT + 3;
   localparam int          T_END  = 2 * OP_LAT + 4;
   localparam logic [31:0] HALF   = 32'h3F00_0000;
   localparam logic [31:0] SQ3_2  = 32'h3F5D_B3D7;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        en      = 1'b0;
   logic [31:0] V_alpha = '0;
   logic [31:0] V_beta  = '0;
   logic [31:0] re_add1, re_add2, re_mult1, re_mult2;
   logic [31:0] add1a, add1b, add2a, add2b;
   logic        isadd1, isadd2;
   logic [31:0] mult1a, mult1b, mult2a, mult2b;
   logic [31:0] U_u, U_v, U_w;
   logic        ack;

   iclark #(.OP_LAT(OP_LAT)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
      .V_alpha(V_alpha), .V_beta(V_beta),
      .re_add1(re_add1), .re_add2(re_add2), .re_mult1(re_mult1), .re_mult2(re_mult2),
      .add1a(add1a), .add1b(add1b), .add2a(add2a), .add2b(add2b),
      .isadd1(isadd1), .isadd2(isadd2),
      .mult1a(mult1a), .mult1b(mult1b), .mult2a(mult2a), .mult2b(mult2b),
      .U_u(U_u), .U_v(U_v), .U_w(U_w), .ack(ack)
   );

   always #5 sys_clk = ~sys_clk;

   // float32 <-> real helpers (normals and zero only)
   function automatic real f2d(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] d2f(input real r);
      logic [63:0] d;
      logic [24:0] m;
      int          e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      m = {2'b01, d[51:29]};
      e = int'(d[62:52]) - 896;
      if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      return d2f(f2d(a) * f2d(b));
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_add);
      return d2f(is_add ? f2d(a) + f2d(b) : f2d(a) - f2d(b));
   endfunction

   function automatic logic [31:0] rand_f();
      if ($urandom_range(0, 7) == 0) return 32'h0000_0000;
      return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   // Shared FP units with latency OP_LAT
   logic [31:0] m1p[OP_LAT], m2p[OP_LAT], a1p[OP_LAT], a2p[OP_LAT];
   always @(posedge sys_clk) begin
      m1p[0] <= fmul(mult1a, mult1b);
      m2p[0] <= fmul(mult2a, mult2b);
      a1p[0] <= fadd(add1a, add1b, isadd1);
      a2p[0] <= fadd(add2a, add2b, isadd2);
      for (int i = 1; i < int'(OP_LAT); i++) begin
         m1p[i] <= m1p[i-1];
         m2p[i] <= m2p[i-1];
         a1p[i] <= a1p[i-1];
         a2p[i] <= a2p[i-1];
      end
   end
   assign re_mult1 = m1p[OP_LAT-1];
   assign re_mult2 = m2p[OP_LAT-1];
   assign re_add1  = a1p[OP_LAT-1];
   assign re_add2  = a2p[OP_LAT-1];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: t = cycles since the accepting edge, -1 when idle
   int          t = -1;
   logic [31:0] cap_a, cap_b, p1, p2;
   logic [31:0] e_m1a, e_m1b, e_m2a, e_m2b, e_a1a, e_a1b, e_a2a, e_a2b;
   logic        e_is1, e_is2, e_ack;
   logic [31:0] e_uu, e_uv, e_uw;

   task automatic model_clear();
      t = -1;
      {e_m1a, e_m1b, e_m2a, e_m2b, e_a1a, e_a1b, e_a2a, e_a2b} = '0;
      {e_is1, e_is2, e_ack} = '0;
      {e_uu, e_uv, e_uw} = '0;
   endtask

   task automatic model_edge();
      if (t < 0) begin
         if (en) begin
            t     = 0;
            cap_a = V_alpha;
            cap_b = V_beta;
            e_m1a = HALF;  e_m1b = V_alpha;
            e_m2a = SQ3_2; e_m2b = V_beta;
         end
      end else begin
         t++;
         if (t == int'(OP_LAT) + 1) begin
            p1    = fmul(HALF, cap_a);
            p2    = fmul(SQ3_2, cap_b);
            e_a1a = p2; e_a1b = p1;
            e_a2a = {~p1[31], p1[30:0]}; e_a2b = p2;
            e_is1 = 1'b0; e_is2 = 1'b0;
         end
         if (t == T_UPD) begin
            e_uu = cap_a;
            e_uv = fadd(p2, p1, 1'b0);
            e_uw = fadd({~p1[31], p1[30:0]}, p2, 1'b0);
         end
         if (t == T_END) t = -1;
      end
      e_ack = (t == T_UPD);
   endtask

   task automatic check_all();
      check("ack", 32'(ack), 32'(e_ack));
      check("U_u", U_u, e_uu);
      check("U_v", U_v, e_uv);
      check("U_w", U_w, e_uw);
      check("mult1a", mult1a, e_m1a);
      check("mult1b", mult1b, e_m1b);
      check("mult2a", mult2a, e_m2a);
      check("mult2b", mult2b, e_m2b);
      check("add1a", add1a, e_a1a);
      check("add1b", add1b, e_a1b);
      check("add2a", add2a, e_a2a);
      check("add2b", add2b, e_a2b);
      check("isadd", 32'({isadd1, isadd2}), 32'({e_is1, e_is2}));
   endtask

   task automatic step();
      @(posedge sys_clk);
      if (rst_n) model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n, input logic rand_in);
      for (int i = 0; i < n; i++) begin
         if (rand_in) begin
            V_alpha = rand_f();
            V_beta  = rand_f();
         end
         step();
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      V_alpha = a;
      V_beta  = b;
      en      = 1'b1;
      step();
      en      = 1'b0;
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1 model_clear();
      check_all();
      run(2, 1'b1);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #3 model_clear();
      check_all();
      run(2, 1'b0);
      #2 rst_n = 1'b1;

      // alpha = 1, beta = 0
      start(32'h3F80_0000, 32'h0000_0000);
      run(T_END + 2, 1'b1);
      check("dir1_uu", U_u, 32'h3F80_0000);
      check("dir1_uv", U_v, 32'hBF00_0000);
      check("dir1_uw", U_w, 32'hBF00_0000);

      // alpha = 0, beta = 1 (exercises the -0 sign flip)
      start(32'h0000_0000, 32'h3F80_0000);
      run(T_END + 2, 1'b1);
      check("dir2_uu", U_u, 32'h0000_0000);
      check("dir2_uv", U_v, 32'h3F5D_B3D7);
      check("dir2_uw", U_w, 32'hBF5D_B3D7);

      for (int k = 0; k < 6; k++) begin
         start(rand_f(), rand_f());
         run(T_END + int'($urandom_range(0, 5)), 1'b1);
      end

      // reset while in ADD phase, then a clean transform
      start(rand_f(), rand_f());
      run(int'(OP_LAT) + 6, 1'b1);
      mid_reset();
      run(3, 1'b1);
      start(rand_f(), rand_f());
      run(T_END + 2, 1'b1);

      // reset during MULT phase
      start(rand_f(), rand_f());
      run(4, 1'b1);
      mid_reset();
      run(2, 1'b1);

      // en held high with inputs changing every cycle
      en = 1'b1;
      run(100, 1'b1);
      en = 1'b0;
      run(T_END + 2, 1'b1);

      // random en activity, mostly while busy
      for (int i = 0; i < 200; i++) begin
         en = ($urandom_range(0, 3) == 0);
         V_alpha = rand_f();
         V_beta  = rand_f();
         step();
      end
      en = 1'b0;
      run(T_END + 2, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
